// File: rtl/pss_peak_detector.sv
// PSS peak detector: adaptive noise floor, strict threshold trigger, local-max search
// over a short window, then reports the peak with its index and C0/C1 partial sums.
module pss_peak_detector #(
    parameter int IN_DW           = 24,
    parameter int C_DW            = 48,
    parameter int AVG_LOG2        = 3,
    parameter int DETECTION_SHIFT = 2,
    parameter int PEAK_WINDOW     = 4,
    parameter int HOLDOFF         = 8,
    parameter int IDX_DW          = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IN_DW-1:0]  s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    input  logic [C_DW-1:0]   C0_i,
    input  logic [C_DW-1:0]   C1_i,
    input  logic [IN_DW-1:0]  noise_limit_i,
    output logic              peak_detected_o,
    output logic [IN_DW-1:0]  peak_value_o,
    output logic [IDX_DW-1:0] peak_idx_o,
    output logic [C_DW-1:0]   peak_C0_o,
    output logic [C_DW-1:0]   peak_C1_o,
    output logic [1:0]        state_o
);

    localparam int NUM_TAPS = 1 << AVG_LOG2;
    localparam int SUM_W    = IN_DW + AVG_LOG2;
    localparam int THR_W    = IN_DW + DETECTION_SHIFT;
    localparam int CNT_MAX  = (PEAK_WINDOW > HOLDOFF) ? PEAK_WINDOW : HOLDOFF;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_TRACK   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [IN_DW-1:0]    r_ring [NUM_TAPS];
    logic [AVG_LOG2-1:0] r_wrPtr;
    logic [SUM_W-1:0]    r_sum;
    logic [IDX_DW-1:0]   r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cntNext;
    logic [CNT_W-1:0]    w_cntInc;
    logic [IN_DW-1:0]    r_candVal;
    logic [IDX_DW-1:0]   r_candIdx;
    logic [C_DW-1:0]     r_candC0;
    logic [C_DW-1:0]     r_candC1;
    logic                r_pulse;
    logic [IN_DW-1:0]    r_peakVal;
    logic [IDX_DW-1:0]   r_peakIdx;
    logic [C_DW-1:0]     r_peakC0;
    logic [C_DW-1:0]     r_peakC1;

    logic                w_push;
    logic                w_load;
    logic                w_report;
    logic                w_trigger;
    logic [IN_DW-1:0]    w_avg;
    logic [THR_W-1:0]    w_threshold;
    logic [THR_W-1:0]    w_xWide;
    logic [IN_DW-1:0]    w_finalVal;
    logic [IDX_DW-1:0]   w_finalIdx;
    logic [C_DW-1:0]     w_finalC0;
    logic [C_DW-1:0]     w_finalC1;

    // The floor reflects only samples already in the ring, never the one being judged.
    assign w_avg       = r_sum[SUM_W-1:AVG_LOG2];
    assign w_threshold = THR_W'(w_avg) << DETECTION_SHIFT;
    assign w_xWide     = THR_W'(s_axis_in_tdata);
    assign w_trigger   = (s_axis_in_tdata > noise_limit_i) && (w_xWide > w_threshold);
    assign w_cntInc    = r_cnt + CNT_W'(1);

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_push      = 1'b0;
        w_load      = 1'b0;
        w_report    = 1'b0;
        if (s_axis_in_tvalid) begin
            case (r_state)
                ST_WARMUP: begin
                    w_push = 1'b1;
                    if (r_wrPtr == AVG_LOG2'(NUM_TAPS - 1)) begin
                        w_stateNext = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (w_trigger) begin
                        w_load    = 1'b1;
                        w_cntNext = CNT_W'(1);
                        if (PEAK_WINDOW == 1) begin
                            w_report = 1'b1;
                        end else begin
                            w_stateNext = ST_TRACK;
                        end
                    end else begin
                        w_push = 1'b1;
                    end
                end
                ST_TRACK: begin
                    w_load    = (s_axis_in_tdata > r_candVal);
                    w_cntNext = w_cntInc;
                    if (w_cntInc == CNT_W'(PEAK_WINDOW)) begin
                        w_report = 1'b1;
                    end
                end
                default: begin
                    w_cntNext = w_cntInc;
                    if (w_cntInc == CNT_W'(HOLDOFF)) begin
                        w_stateNext = ST_SEARCH;
                        w_cntNext   = '0;
                    end
                end
            endcase
            if (w_report) begin
                w_stateNext = (HOLDOFF == 0) ? ST_SEARCH : ST_HOLDOFF;
                w_cntNext   = '0;
            end
        end
    end

    // A report must include the sample accepted on the same edge if it is the new maximum.
    assign w_finalVal = w_load ? s_axis_in_tdata : r_candVal;
    assign w_finalIdx = w_load ? r_idx           : r_candIdx;
    assign w_finalC0  = w_load ? C0_i            : r_candC0;
    assign w_finalC1  = w_load ? C1_i            : r_candC1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_WARMUP;
            r_cnt     <= '0;
            r_wrPtr   <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_candVal <= '0;
            r_candIdx <= '0;
            r_candC0  <= '0;
            r_candC1  <= '0;
            r_pulse   <= 1'b0;
            r_peakVal <= '0;
            r_peakIdx <= '0;
            r_peakC0  <= '0;
            r_peakC1  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_ring[i] <= '0;
            end
        end else begin
            r_pulse <= w_report;
            if (s_axis_in_tvalid) begin
                r_state <= w_stateNext;
                r_cnt   <= w_cntNext;
                r_idx   <= r_idx + IDX_DW'(1);
                if (w_push) begin
                    r_ring[r_wrPtr] <= s_axis_in_tdata;
                    r_wrPtr         <= r_wrPtr + AVG_LOG2'(1);
                    r_sum           <= r_sum + SUM_W'(s_axis_in_tdata) - SUM_W'(r_ring[r_wrPtr]);
                end
                if (w_load) begin
                    r_candVal <= s_axis_in_tdata;
                    r_candIdx <= r_idx;
                    r_candC0  <= C0_i;
                    r_candC1  <= C1_i;
                end
                if (w_report) begin
                    r_peakVal <= w_finalVal;
                    r_peakIdx <= w_finalIdx;
                    r_peakC0  <= w_finalC0;
                    r_peakC1  <= w_finalC1;
                end
            end
        end
    end

    assign peak_detected_o = r_pulse;
    assign peak_value_o    = r_peakVal;
    assign peak_idx_o      = r_peakIdx;
    assign peak_C0_o       = r_peakC0;
    assign peak_C1_o       = r_peakC1;
    assign state_o         = r_state;

endmodule

// File: tb/tb_pss_peak_detector.sv
// Directed bench for pss_peak_detector: a transaction-level model checked every cycle,
// plus hand-computed literal checks of reported peaks.
module tb_pss_peak_detector;

    localparam int IN_DW  = 24;
    localparam int C_DW   = 48;
    localparam int IDX_DW = 32;
    localparam int NTAPS  = 8;
    localparam int SHIFT  = 2;
    localparam int PW     = 4;
    localparam int HOLD   = 8;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic [IN_DW-1:0]  s_axis_in_tdata = '0;
    logic              s_axis_in_tvalid = 1'b0;
    logic [C_DW-1:0]   C0_i = '0;
    logic [C_DW-1:0]   C1_i = '0;
    logic [IN_DW-1:0]  noise_limit_i = '0;
    logic              peak_detected_o;
    logic [IN_DW-1:0]  peak_value_o;
    logic [IDX_DW-1:0] peak_idx_o;
    logic [C_DW-1:0]   peak_C0_o;
    logic [C_DW-1:0]   peak_C1_o;
    logic [1:0]        state_o;

    int vectorCount = 0;
    int missCount   = 0;
    bit checking    = 1'b0;
    int sampleNo    = 0;

    pss_peak_detector dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .s_axis_in_tdata  (s_axis_in_tdata),
        .s_axis_in_tvalid (s_axis_in_tvalid),
        .C0_i             (C0_i),
        .C1_i             (C1_i),
        .noise_limit_i    (noise_limit_i),
        .peak_detected_o  (peak_detected_o),
        .peak_value_o     (peak_value_o),
        .peak_idx_o       (peak_idx_o),
        .peak_C0_o        (peak_C0_o),
        .peak_C1_o        (peak_C1_o),
        .state_o          (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: floor is the mean of the last eight pushed samples.
    int unsigned       floorQ[$];
    int                mMode;
    int                mWarm, mWin, mHold;
    logic [IDX_DW-1:0] mIdx;
    longint unsigned   cVal;
    logic [IDX_DW-1:0] cIdx;
    logic [C_DW-1:0]   cC0, cC1;
    bit                expPulse;
    longint unsigned   expVal;
    logic [IDX_DW-1:0] expIdx;
    logic [C_DW-1:0]   expC0, expC1;

    function automatic longint unsigned floorAvg();
        longint unsigned s = 0;
        foreach (floorQ[i]) s += floorQ[i];
        return s / NTAPS;
    endfunction

    task automatic pushFloor(input int unsigned x);
        floorQ.push_back(x);
        if (floorQ.size() > NTAPS) void'(floorQ.pop_front());
    endtask

    always @(posedge clk_i) begin
        if (reset_i) begin
            floorQ = {};
            mMode = 0; mWarm = 0; mWin = 0; mHold = 0; mIdx = '0;
            cVal = 0; cIdx = '0; cC0 = '0; cC1 = '0;
            expPulse = 0; expVal = 0; expIdx = '0; expC0 = '0; expC1 = '0;
        end else begin
            bit rep;
            longint unsigned x;
            rep = 0;
            expPulse = 0;
            if (s_axis_in_tvalid) begin
                x = longint'(s_axis_in_tdata);
                case (mMode)
                    0: begin
                        pushFloor(int'(x));
                        mWarm++;
                        if (mWarm == NTAPS) mMode = 1;
                    end
                    1: begin
                        if (x > longint'(noise_limit_i) && x > (floorAvg() * (1 << SHIFT))) begin
                            cVal = x; cIdx = mIdx; cC0 = C0_i; cC1 = C1_i;
                            mWin = 1;
                            if (mWin == PW) rep = 1; else mMode = 2;
                        end else begin
                            pushFloor(int'(x));
                        end
                    end
                    2: begin
                        if (x > cVal) begin
                            cVal = x; cIdx = mIdx; cC0 = C0_i; cC1 = C1_i;
                        end
                        mWin++;
                        if (mWin == PW) rep = 1;
                    end
                    default: begin
                        mHold++;
                        if (mHold == HOLD) mMode = 1;
                    end
                endcase
                if (rep) begin
                    expPulse = 1;
                    expVal = cVal; expIdx = cIdx; expC0 = cC0; expC1 = cC1;
                    mMode = (HOLD > 0) ? 3 : 1;
                    mHold = 0;
                end
                mIdx = mIdx + 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (checking) begin
            checkOutput("model pulse", 64'(peak_detected_o), 64'(expPulse));
            checkOutput("model value", 64'(peak_value_o), expVal);
            checkOutput("model idx",   64'(peak_idx_o), 64'(expIdx));
            checkOutput("model C0",    64'(peak_C0_o), 64'(expC0));
            checkOutput("model C1",    64'(peak_C1_o), 64'(expC1));
            checkOutput("model state", 64'(state_o), 64'(mMode));
        end
    end

    task automatic applyStimulus(input int unsigned x);
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b1;
        s_axis_in_tdata  = IN_DW'(x);
        C0_i = C_DW'(sampleNo * 1000 + 7);
        C1_i = 48'h8000_0000_0000 | C_DW'(sampleNo);
        sampleNo++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            s_axis_in_tvalid = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clk_i);
        reset_i = 1'b1;
        s_axis_in_tvalid = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        sampleNo = 0;
    endtask

    task automatic warmFloor();
        for (int i = 0; i < NTAPS; i++) applyStimulus(100);
    endtask

    task automatic checkPeak(input string name, input int unsigned val, input int unsigned idx);
        checkOutput({name, " pulse"}, 64'(peak_detected_o), 64'd1);
        checkOutput({name, " value"}, 64'(peak_value_o), 64'(val));
        checkOutput({name, " idx"},   64'(peak_idx_o), 64'(idx));
        checkOutput({name, " C0"},    64'(peak_C0_o), 64'(idx * 1000 + 7));
        checkOutput({name, " C1"},    64'(peak_C1_o), 64'h8000_0000_0000 | 64'(idx));
    endtask

    initial begin
        int unsigned warmVals[8];
        int unsigned basicVals[4];
        warmVals  = '{100, 100, 100, 5000, 100, 100, 100, 100};
        basicVals = '{401, 600, 500, 300};

        doReset();
        checking = 1'b1;
        checkOutput("reset state", 64'(state_o), 64'd0);
        checkOutput("reset value", 64'(peak_value_o), 64'd0);
        checkOutput("reset pulse", 64'(peak_detected_o), 64'd0);

        // Warmup
        for (int i = 0; i < 7; i++) applyStimulus(warmVals[i]);
        idle(1);
        checkOutput("warmup state after 7", 64'(state_o), 64'd0);
        applyStimulus(warmVals[7]);
        idle(1);
        checkOutput("warmup state after 8", 64'(state_o), 64'd1);
        idle(2);

        // Basic detection, then holdoff with frozen floor
        doReset();
        warmFloor();
        foreach (basicVals[i]) applyStimulus(basicVals[i]);
        idle(1);
        checkPeak("basic", 600, 9);
        idle(1);
        checkOutput("basic pulse one cycle", 64'(peak_detected_o), 64'd0);
        checkOutput("holdoff state", 64'(state_o), 64'd3);
        for (int i = 0; i < HOLD; i++) applyStimulus(5000);
        applyStimulus(5000);
        for (int i = 0; i < 3; i++) applyStimulus(100);
        idle(1);
        checkPeak("frozen floor", 5000, 20);
        idle(3);

        // Threshold boundary
        doReset();
        warmFloor();
        applyStimulus(400);
        applyStimulus(549);
        for (int i = 0; i < 3; i++) applyStimulus(100);
        idle(1);
        checkPeak("threshold", 549, 9);
        idle(2);

        // Absolute limit
        doReset();
        noise_limit_i = 1000;
        warmFloor();
        applyStimulus(900);
        applyStimulus(1001);
        for (int i = 0; i < 3; i++) applyStimulus(100);
        idle(1);
        checkPeak("noise limit", 1001, 9);
        noise_limit_i = 0;
        idle(2);

        // Gapped valid during TRACK
        doReset();
        warmFloor();
        foreach (basicVals[i]) begin
            applyStimulus(basicVals[i]);
            if (i < 3) idle(1);
        end
        idle(1);
        checkPeak("gapped", 600, 9);
        idle(2);

        // Reset in the middle of TRACK
        doReset();
        warmFloor();
        applyStimulus(401);
        applyStimulus(600);
        doReset();
        idle(4);
        checkOutput("midreset pulse", 64'(peak_detected_o), 64'd0);
        checkOutput("midreset state", 64'(state_o), 64'd0);
        checkOutput("midreset value", 64'(peak_value_o), 64'd0);
        checkOutput("midreset idx", 64'(peak_idx_o), 64'd0);
        warmFloor();
        applyStimulus(401);
        for (int i = 0; i < 3; i++) applyStimulus(100);
        idle(1);
        checkPeak("after reset", 401, 8);
        idle(2);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
